// File: rtl/mem_port_arbiter.sv
// Arbitrates the external memory port between I$ refill, D$ refill and the store buffer drain.
// Winner's request is registered onto the bus; read bursts stay owned until the rlast beat.
module mem_port_arbiter #(
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned WR_STARVE      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd0_valid_i,
    input  logic [31:0] rd0_addr_i,
    output logic        rd0_ready_o,
    output logic        rd0_data_valid_o,
    input  logic        rd1_valid_i,
    input  logic [31:0] rd1_addr_i,
    output logic        rd1_ready_o,
    output logic        rd1_data_valid_o,
    output logic [31:0] rd_data_o,
    output logic        rd_last_o,
    input  logic        wr_valid_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_wdata_i,
    input  logic [3:0]  wr_wstrb_i,
    output logic        wr_ready_o,
    output logic        bus_valid_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_ready_i,
    input  logic        bus_rdata_valid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_rlast_i,
    output logic        busy_o,
    output logic        proto_err_o
);
    localparam int unsigned OFF = $clog2(4 * WORDS_PER_LINE);
    localparam int unsigned BW  = $clog2(WORDS_PER_LINE) + 1;
    localparam int unsigned WW  = $clog2(WR_STARVE + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_REQ  = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;
    localparam logic [1:0] WR_REQ  = 2'd3;

    logic [1:0]    state_q;
    logic          owner_q;
    logic          we_q;
    logic          rr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [WW-1:0] wr_wait_q;
    logic [BW-1:0] beat_q;
    logic          proto_err_q;

    logic el0, el1, gnt_wr, gnt_rd, gnt_id, beat_in, beat_last;
    logic [31:0] rd_line_addr;

    // Reads that hit the pending write's line wait so the write lands first (RAW).
    always_comb begin
        el0          = rd0_valid_i && !(wr_valid_i && (wr_addr_i[31:OFF] == rd0_addr_i[31:OFF]));
        el1          = rd1_valid_i && !(wr_valid_i && (wr_addr_i[31:OFF] == rd1_addr_i[31:OFF]));
        gnt_wr       = wr_valid_i && ((wr_wait_q >= WW'(WR_STARVE)) || !(el0 || el1));
        gnt_rd       = !gnt_wr && (el0 || el1);
        gnt_id       = (el0 && el1) ? rr_q : el1;
        rd_line_addr = gnt_id ? {rd1_addr_i[31:OFF], {OFF{1'b0}}}
                              : {rd0_addr_i[31:OFF], {OFF{1'b0}}};
        beat_in      = (state_q == RD_DATA) && bus_rdata_valid_i;
        beat_last    = (beat_q == BW'(WORDS_PER_LINE - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            rr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wr_wait_q   <= '0;
            beat_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!wr_valid_i) wr_wait_q <= '0;
                    if (gnt_wr) begin
                        state_q   <= WR_REQ;
                        we_q      <= 1'b1;
                        addr_q    <= wr_addr_i;
                        wdata_q   <= wr_wdata_i;
                        wstrb_q   <= wr_wstrb_i;
                        wr_wait_q <= '0;
                    end else if (gnt_rd) begin
                        state_q <= RD_REQ;
                        we_q    <= 1'b0;
                        owner_q <= gnt_id;
                        rr_q    <= ~gnt_id;
                        addr_q  <= rd_line_addr;
                        wdata_q <= '0;
                        wstrb_q <= '0;
                        if (wr_valid_i && (wr_wait_q < WW'(WR_STARVE)))
                            wr_wait_q <= wr_wait_q + 1'b1;
                    end
                end
                RD_REQ: begin
                    if (bus_ready_i) begin
                        state_q <= RD_DATA;
                        beat_q  <= '0;
                    end
                end
                RD_DATA: begin
                    if (bus_rdata_valid_i) begin
                        if (bus_rlast_i != beat_last) proto_err_q <= 1'b1;
                        if (bus_rlast_i) begin
                            state_q <= IDLE;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (bus_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (bus_rdata_valid_i && (state_q != RD_DATA)) proto_err_q <= 1'b1;
        end
    end

    always_comb begin
        bus_valid_o      = (state_q == RD_REQ) || (state_q == WR_REQ);
        bus_we_o         = we_q;
        bus_addr_o       = addr_q;
        bus_wdata_o      = wdata_q;
        bus_wstrb_o      = wstrb_q;
        rd0_ready_o      = (state_q == RD_REQ) && bus_ready_i && !owner_q;
        rd1_ready_o      = (state_q == RD_REQ) && bus_ready_i && owner_q;
        wr_ready_o       = (state_q == WR_REQ) && bus_ready_i;
        rd0_data_valid_o = beat_in && !owner_q;
        rd1_data_valid_o = beat_in && owner_q;
        rd_data_o        = beat_in ? bus_rdata_i : '0;
        rd_last_o        = beat_in && bus_rlast_i;
        busy_o           = (state_q != IDLE);
        proto_err_o      = proto_err_q;
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd0_addr_i[OFF-1:0], rd1_addr_i[OFF-1:0]};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int WPL    = 4;
    localparam int STARVE = 4;
    localparam int OFF    = $clog2(4 * WPL);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd0_valid_i = 0, rd1_valid_i = 0, wr_valid_i = 0;
    logic [31:0] rd0_addr_i = 0, rd1_addr_i = 0, wr_addr_i = 0, wr_wdata_i = 0;
    logic [3:0]  wr_wstrb_i = 0;
    logic        bus_ready_i = 0, bus_rdata_valid_i = 0, bus_rlast_i = 0;
    logic [31:0] bus_rdata_i = 0;
    logic        rd0_ready_o, rd1_ready_o, rd0_data_valid_o, rd1_data_valid_o, rd_last_o;
    logic        wr_ready_o, bus_valid_o, bus_we_o, busy_o, proto_err_o;
    logic [31:0] rd_data_o, bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_wstrb_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORDS_PER_LINE(WPL), .WR_STARVE(STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd0_valid_i(rd0_valid_i), .rd0_addr_i(rd0_addr_i), .rd0_ready_o(rd0_ready_o),
        .rd0_data_valid_o(rd0_data_valid_o),
        .rd1_valid_i(rd1_valid_i), .rd1_addr_i(rd1_addr_i), .rd1_ready_o(rd1_ready_o),
        .rd1_data_valid_o(rd1_data_valid_o),
        .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
        .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_wdata_i(wr_wdata_i),
        .wr_wstrb_i(wr_wstrb_i), .wr_ready_o(wr_ready_o),
        .bus_valid_o(bus_valid_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o), .bus_ready_i(bus_ready_i),
        .bus_rdata_valid_i(bus_rdata_valid_i), .bus_rdata_i(bus_rdata_i),
        .bus_rlast_i(bus_rlast_i), .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: who the next tie goes to, reads granted over a waiting write, sticky error.
    int m_rr   = 0;
    int m_wait = 0;
    bit m_err  = 0;

    logic [31:0] pool [5] = '{32'h0000_2000, 32'h0000_2004, 32'h0000_3000, 32'h0000_3010, 32'h0000_4000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_bus_valid"}, bus_valid_o, 0);
        chk({tag, "_bus_we"}, bus_we_o, 0);
        chk({tag, "_bus_addr"}, bus_addr_o, 0);
        chk({tag, "_bus_wdata"}, bus_wdata_o, 0);
        chk({tag, "_bus_wstrb"}, bus_wstrb_o, 0);
        chk({tag, "_readys"}, {rd0_ready_o, rd1_ready_o, wr_ready_o}, 0);
        chk({tag, "_dvalids"}, {rd0_data_valid_o, rd1_data_valid_o, rd_last_o}, 0);
        chk({tag, "_rd_data"}, rd_data_o, 0);
        chk({tag, "_proto_err"}, proto_err_o, 0);
    endtask

    // Winner from the priority rules: 0 = rd0, 1 = rd1, 2 = write, 3 = nobody.
    function automatic int pick(bit v0, logic [31:0] a0, bit v1, logic [31:0] a1,
                                bit wv, logic [31:0] wa);
        bit e0 = v0 && !(wv && ((wa >> OFF) == (a0 >> OFF)));
        bit e1 = v1 && !(wv && ((wa >> OFF) == (a1 >> OFF)));
        if (wv && (m_wait >= STARVE || !(e0 || e1))) return 2;
        if (e0 && e1) return m_rr;
        if (e0) return 0;
        if (e1) return 1;
        return 3;
    endfunction

    // Entered at posedge+1 with the DUT idle; leaves at posedge+1 with the DUT idle again
    // (or just out of reset when rst_beat >= 0).
    task automatic txn(input bit v0, input logic [31:0] a0, input bit v1, input logic [31:0] a1,
                       input bit wv, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input int acc_dly, input int last_beat,
                       input int rst_beat);
        int who;
        logic [31:0] exp_addr;
        int i;
        bit done;
        rd0_valid_i = v0; rd0_addr_i = a0;
        rd1_valid_i = v1; rd1_addr_i = a1;
        wr_valid_i = wv; wr_addr_i = wa; wr_wdata_i = wd; wr_wstrb_i = ws;
        who = pick(v0, a0, v1, a1, wv, wa);
        @(negedge clk);
        chk("idle_busy", busy_o, 0);
        chk("idle_bus_valid", bus_valid_o, 0);
        if (who == 2) m_wait = 0;
        else if (who < 2) begin
            m_wait = wv ? ((m_wait < STARVE) ? m_wait + 1 : STARVE) : 0;
            m_rr = 1 - who;
        end else if (!wv) m_wait = 0;
        @(posedge clk); #1;
        if (who == 3) return;
        exp_addr = (who == 2) ? wa : (((who == 0) ? a0 : a1) & ~((32'd1 << OFF) - 1));
        for (int d = 0; d < acc_dly; d++) begin
            rd0_valid_i = 1'($urandom); rd1_valid_i = 1'($urandom); wr_valid_i = 1'($urandom);
            rd0_addr_i = $urandom; rd1_addr_i = $urandom; wr_addr_i = $urandom;
            wr_wdata_i = $urandom; wr_wstrb_i = 4'($urandom);
            @(negedge clk);
            chk("stall_bus_valid", bus_valid_o, 1);
            chk("stall_bus_we", bus_we_o, (who == 2));
            chk("stall_bus_addr", bus_addr_o, exp_addr);
            if (who == 2) begin
                chk("stall_bus_wdata", bus_wdata_o, wd);
                chk("stall_bus_wstrb", bus_wstrb_o, ws);
            end
            chk("stall_readys", {rd0_ready_o, rd1_ready_o, wr_ready_o}, 0);
            @(posedge clk); #1;
        end
        bus_ready_i = 1;
        @(negedge clk);
        chk("acc_bus_valid", bus_valid_o, 1);
        chk("acc_bus_we", bus_we_o, (who == 2));
        chk("acc_bus_addr", bus_addr_o, exp_addr);
        if (who == 2) chk("acc_bus_wdata", {bus_wdata_o, 28'd0, bus_wstrb_o}, {wd, 28'd0, ws});
        chk("acc_readys", {rd0_ready_o, rd1_ready_o, wr_ready_o},
            {(who == 0), (who == 1), (who == 2)});
        @(posedge clk); #1;
        bus_ready_i = 0;
        rd0_valid_i = 0; rd1_valid_i = 0; wr_valid_i = 0;
        if (who < 2) begin
            i = 0;
            done = 0;
            while (!done) begin
                if ($urandom_range(3) == 0) begin
                    @(negedge clk);
                    chk("gap_dvalids", {rd0_data_valid_o, rd1_data_valid_o, rd_last_o}, 0);
                    chk("gap_busy", busy_o, 1);
                    @(posedge clk); #1;
                end
                bus_rdata_valid_i = 1;
                bus_rdata_i = $urandom;
                bus_rlast_i = (i == last_beat);
                if (i == rst_beat) begin
                    rst_n = 0;
                    #1;
                    chk_all_zero("rst_mid");
                    m_rr = 0; m_wait = 0; m_err = 0;
                    @(posedge clk); #1;
                    bus_rdata_valid_i = 0; bus_rlast_i = 0;
                    @(posedge clk); #1;
                    rst_n = 1;
                    return;
                end
                @(negedge clk);
                chk("beat_dv0", rd0_data_valid_o, (who == 0));
                chk("beat_dv1", rd1_data_valid_o, (who == 1));
                chk("beat_data", rd_data_o, bus_rdata_i);
                chk("beat_last", rd_last_o, bus_rlast_i);
                if ((i == last_beat) != (i == WPL - 1)) m_err = 1;
                @(posedge clk); #1;
                bus_rdata_valid_i = 0; bus_rlast_i = 0;
                done = (i == last_beat);
                i++;
            end
        end
        chk("proto_err", proto_err_o, m_err);
    endtask

    initial begin
        #1;
        chk_all_zero("rst_hold");
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst_hold2");
        rst_n = 1;

        // Lone rd1 refill, immediate accept.
        txn(0, 0, 1, 32'h0000_1234, 0, 0, 0, 0, 0, 3, -1);
        // Both readers streaming: grants alternate.
        for (int k = 0; k < 4; k++)
            txn(1, 32'h0000_0100, 1, 32'h0000_0200, 0, 0, 0, 0, $urandom_range(2), 3, -1);
        // RAW hazard: write to the same line goes first.
        txn(0, 0, 1, 32'h0000_2000, 1, 32'h0000_2008, 32'hDEAD_BEEF, 4'hF, 1, 3, -1);
        txn(0, 0, 1, 32'h0000_2000, 0, 0, 0, 0, 0, 3, -1);
        // Different line: read goes first, then the write.
        txn(0, 0, 1, 32'h0000_3000, 1, 32'h0000_2008, 32'h1234_5678, 4'h3, 0, 3, -1);
        txn(0, 0, 0, 0, 1, 32'h0000_2008, 32'h1234_5678, 4'h3, 2, 3, -1);
        // Write held under a continuous read stream: forced after WR_STARVE reads.
        for (int k = 0; k < STARVE + 1; k++)
            txn(1, 32'h0000_0100, 1, 32'h0000_0200, 1, 32'h0000_5000, 32'hCAFE_0000 + k, 4'hC, 0, 3, -1);
        // Short burst, then a normal one.
        txn(1, 32'h0000_0400, 0, 0, 0, 0, 0, 0, 0, 1, -1);
        txn(0, 0, 1, 32'h0000_0500, 0, 0, 0, 0, 0, 3, -1);
        // Beat with no burst open.
        bus_rdata_valid_i = 1; bus_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        chk("stray_dvalids", {rd0_data_valid_o, rd1_data_valid_o, rd_last_o}, 0);
        @(posedge clk); #1;
        bus_rdata_valid_i = 0;
        m_err = 1;
        @(negedge clk);
        chk("stray_proto_err", proto_err_o, m_err);
        @(posedge clk); #1;
        // Reset during beat 2, then a tie goes to rd0.
        txn(0, 0, 1, 32'h0000_0600, 0, 0, 0, 0, 0, 3, 1);
        txn(1, 32'h0000_0700, 1, 32'h0000_0800, 0, 0, 0, 0, 0, 3, -1);

        for (int k = 0; k < 60; k++) begin
            int lb;
            lb = ($urandom_range(7) == 0) ? int'($urandom_range(4, 2)) : 3;
            txn(1'($urandom), pool[$urandom_range(4)], 1'($urandom), pool[$urandom_range(4)],
                1'($urandom), pool[$urandom_range(4)] + ($urandom_range(3) << 2),
                $urandom, 4'($urandom), $urandom_range(2), lb, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
